// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment scanner with double-buffered load and dead time
// Optional PWM dimming via `define BRIGHTNESS_EN (adds the bright port).
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 65536,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
`ifdef BRIGHTNESS_EN
  input  logic [2:0]              bright,
`endif
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD     = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_data, ds_data;
  logic [NUM_DIGITS-1:0]   sh_dp, ds_dp, sh_blank, ds_blank;
  logic                    pending;
  logic                    slot_end, frame_end, lit;
  logic [3:0]              nib;
  logic [7:0]              glyph, seg_n;
  logic [NUM_DIGITS-1:0]   anode_n;

  function automatic logic [7:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 8'hC0;  4'h1: decode = 8'hF9;  4'h2: decode = 8'hA4;  4'h3: decode = 8'hB0;
      4'h4: decode = 8'h99;  4'h5: decode = 8'h92;  4'h6: decode = 8'h82;  4'h7: decode = 8'hF8;
      4'h8: decode = 8'h80;  4'h9: decode = 8'h90;  4'hA: decode = 8'h88;  4'hB: decode = 8'h83;
      4'hC: decode = 8'hC6;  4'hD: decode = 8'hA1;  4'hE: decode = 8'h86;  default: decode = 8'h8E;
    endcase
  endfunction

  always_comb begin
    slot_end  = cnt == CNT_LAST;
    frame_end = slot_end && idx == IDX_LAST;
    nib       = ds_data[4*idx +: 4];
    glyph     = decode(nib);
`ifdef BRIGHTNESS_EN
    lit       = cnt >= DEAD && !ds_blank[idx] && cnt[2:0] <= bright;
`else
    lit       = cnt >= DEAD && !ds_blank[idx];
`endif
    seg_n     = lit ? {~ds_dp[idx], glyph[6:0]} : 8'hFF;
    anode_n   = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '1;
      ds_data    <= '0;
      ds_dp      <= '0;
      ds_blank   <= '1;
      pending    <= 1'b0;
      seg_out    <= 8'hFF;
      anode      <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      idx        <= slot_end ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
      seg_out    <= seg_n;
      anode      <= anode_n;
      frame_tick <= frame_end;
      if (frame_end && pending) begin
        ds_data  <= sh_data;
        ds_dp    <= sh_dp;
        ds_blank <= sh_blank;
      end
      // a load on the boundary edge re-arms pending so its values show next frame
      if (load) begin
        sh_data  <= data_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end
      pending <= load | (pending & ~frame_end);
    end
  end
endmodule
